// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline control slice: sequencer states,
// per-cycle event classes, packed stage-control bundles and opcodes used by hazard detection.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } stallStateT;

    // Highest-priority event of a cycle; drives both the stage controls and the perf counters
    typedef enum logic [2:0] {
        EV_RESET     = 3'd0,
        EV_FREEZE    = 3'd1,
        EV_REDIRECT  = 3'd2,
        EV_DISCARD   = 3'd3,
        EV_HAZARD    = 3'd4,
        EV_FETCHWAIT = 3'd5,
        EV_NORMAL    = 3'd6
    } stallEventT;

    typedef struct packed {
        logic pcWrite;
        logic ifIdWrite;
        logic idExWrite;
        logic exMemWrite;
        logic memWbWrite;
        logic ifIdFlush;
        logic idExFlush;
    } stageCtrlT;

    localparam stageCtrlT CTRL_RESET     = 7'b00000_11;
    localparam stageCtrlT CTRL_FREEZE    = 7'b00000_00;
    localparam stageCtrlT CTRL_REDIRECT  = 7'b11111_11;
    localparam stageCtrlT CTRL_DISCARD   = 7'b11111_10;
    localparam stageCtrlT CTRL_HAZARD    = 7'b01111_01;
    localparam stageCtrlT CTRL_FETCHWAIT = 7'b01111_10;
    localparam stageCtrlT CTRL_NORMAL    = 7'b11111_00;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    function automatic logic isControlTransfer(input logic [6:0] opcode);
        return (opcode == OPC_BRANCH) || (opcode == OPC_JALR) || (opcode == OPC_JAL);
    endfunction

endpackage

// File: rtl/stall_wait_counter.sv
// Counter with limit compare: saturating for the data-memory wait timer, wrapping for
// the performance counters (SATURATE=0).
module stall_wait_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int MEM_TIMEOUT = 64,
    parameter bit SATURATE    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             atLimit
);

    localparam logic [CNT_W-1:0] COUNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && !(SATURATE && (count == COUNT_MAX))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Asserted in the cycle whose increment starts from the limit value
    assign atLimit = inc && (count >= LIMIT);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional performance counters are built when STALL_PERF_CNT_EN is defined.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_hazardStall,
    input  logic        EX_redirect,
    input  logic        IF_ready,
    input  logic        MEM_req,
    input  logic        MEM_ready,
    output logic        PCWrite,
    output logic        IF_IDWrite,
    output logic        ID_EXWrite,
    output logic        EX_MEMWrite,
    output logic        MEM_WBWrite,
    output logic        IF_IDFlush,
    output logic        ID_EXFlush,
    output logic        mem_timeout,
    output logic [1:0]  state_o
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] perf_hazard,
    output logic [31:0] perf_redirect,
    output logic [31:0] perf_memwait,
    output logic [31:0] perf_fetchwait
`endif
);

    stallStateT       state;
    stallStateT       nextState;
    stallEventT       cycleEvent;
    stageCtrlT        ctrl;
    logic             freeze;
    logic             waitAtLimit;
    logic             memTimeoutReg;
    logic [CNT_W-1:0] unusedWaitCnt;

    assign freeze = MEM_req && !MEM_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // A redirect while frozen is ignored: EX holds, so the request is seen again on release
    always_comb begin
        cycleEvent = EV_NORMAL;
        nextState  = RUN;
        if (reset) begin
            cycleEvent = EV_RESET;
        end else if (freeze) begin
            cycleEvent = EV_FREEZE;
            nextState  = MEM_WAIT;
        end else if (EX_redirect) begin
            cycleEvent = EV_REDIRECT;
            nextState  = REDIRECT;
        end else if (state == REDIRECT) begin
            cycleEvent = EV_DISCARD;
        end else if (ID_hazardStall) begin
            cycleEvent = EV_HAZARD;
        end else if (!IF_ready) begin
            cycleEvent = EV_FETCHWAIT;
        end
    end

    always_comb begin
        ctrl = CTRL_NORMAL;
        case (cycleEvent)
            EV_RESET:     ctrl = CTRL_RESET;
            EV_FREEZE:    ctrl = CTRL_FREEZE;
            EV_REDIRECT:  ctrl = CTRL_REDIRECT;
            EV_DISCARD:   ctrl = CTRL_DISCARD;
            EV_HAZARD:    ctrl = CTRL_HAZARD;
            EV_FETCHWAIT: ctrl = CTRL_FETCHWAIT;
            EV_NORMAL:    ctrl = CTRL_NORMAL;
            default:      ctrl = CTRL_NORMAL;
        endcase
    end

    assign PCWrite     = ctrl.pcWrite;
    assign IF_IDWrite  = ctrl.ifIdWrite;
    assign ID_EXWrite  = ctrl.idExWrite;
    assign EX_MEMWrite = ctrl.exMemWrite;
    assign MEM_WBWrite = ctrl.memWbWrite;
    assign IF_IDFlush  = ctrl.ifIdFlush;
    assign ID_EXFlush  = ctrl.idExFlush;
    assign state_o     = state;

    stall_wait_counter #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .SATURATE    (1'b1)
    ) waitCounter (
        .clk     (clk),
        .reset   (reset),
        .clear   (!freeze),
        .inc     (freeze),
        .count   (unusedWaitCnt),
        .atLimit (waitAtLimit)
    );

    // Sticky until reset; the pipeline itself keeps waiting on the memory
    always_ff @(posedge clk) begin
        if (reset) begin
            memTimeoutReg <= 1'b0;
        end else if (waitAtLimit) begin
            memTimeoutReg <= 1'b1;
        end
    end

    assign mem_timeout = memTimeoutReg && !reset;

`ifdef STALL_PERF_CNT_EN
    logic [3:0]  unusedPerfLimit;
    logic [3:0]  perfInc;
    logic [31:0] perfCount [4];

    assign perfInc = {cycleEvent == EV_FETCHWAIT, cycleEvent == EV_FREEZE,
                      cycleEvent == EV_REDIRECT,  cycleEvent == EV_HAZARD};

    for (genvar i = 0; i < 4; i++) begin : gPerf
        stall_wait_counter #(
            .CNT_W       (32),
            .MEM_TIMEOUT (2),
            .SATURATE    (1'b0)
        ) perfCounter (
            .clk     (clk),
            .reset   (reset),
            .clear   (1'b0),
            .inc     (perfInc[i]),
            .count   (perfCount[i]),
            .atLimit (unusedPerfLimit[i])
        );
    end

    assign perf_hazard    = perfCount[0];
    assign perf_redirect  = perfCount[1];
    assign perf_memwait   = perfCount[2];
    assign perf_fetchwait = perfCount[3];
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller (MEM_TIMEOUT=4).
// Perf-counter checks are compiled only when STALL_PERF_CNT_EN is defined.
module tb_pipeline_stall_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;

    // {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite, IF_IDFlush, ID_EXFlush}
    localparam logic [6:0] EXP_RESET     = 7'b00000_11;
    localparam logic [6:0] EXP_FREEZE    = 7'b00000_00;
    localparam logic [6:0] EXP_REDIRECT  = 7'b11111_11;
    localparam logic [6:0] EXP_DISCARD   = 7'b11111_10;
    localparam logic [6:0] EXP_HAZARD    = 7'b01111_01;
    localparam logic [6:0] EXP_FETCHWAIT = 7'b01111_10;
    localparam logic [6:0] EXP_NORMAL    = 7'b11111_00;

    logic       clk;
    logic       reset;
    logic       ID_hazardStall;
    logic       EX_redirect;
    logic       IF_ready;
    logic       MEM_req;
    logic       MEM_ready;
    logic       PCWrite;
    logic       IF_IDWrite;
    logic       ID_EXWrite;
    logic       EX_MEMWrite;
    logic       MEM_WBWrite;
    logic       IF_IDFlush;
    logic       ID_EXFlush;
    logic       mem_timeout;
    logic [1:0] state_o;
    logic [6:0] ctrlObs;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_hazard;
    logic [31:0] perf_redirect;
    logic [31:0] perf_memwait;
    logic [31:0] perf_fetchwait;
`endif

    int testCount = 0;
    int failCount = 0;

    pipeline_stall_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_hazardStall (ID_hazardStall),
        .EX_redirect    (EX_redirect),
        .IF_ready       (IF_ready),
        .MEM_req        (MEM_req),
        .MEM_ready      (MEM_ready),
        .PCWrite        (PCWrite),
        .IF_IDWrite     (IF_IDWrite),
        .ID_EXWrite     (ID_EXWrite),
        .EX_MEMWrite    (EX_MEMWrite),
        .MEM_WBWrite    (MEM_WBWrite),
        .IF_IDFlush     (IF_IDFlush),
        .ID_EXFlush     (ID_EXFlush),
        .mem_timeout    (mem_timeout),
        .state_o        (state_o)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_hazard    (perf_hazard),
        .perf_redirect  (perf_redirect),
        .perf_memwait   (perf_memwait),
        .perf_fetchwait (perf_fetchwait)
`endif
    );

    assign ctrlObs = {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite, MEM_WBWrite,
                      IF_IDFlush, ID_EXFlush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic applyStimulus(input logic rst, input logic haz, input logic redir,
                                 input logic ifRdy, input logic mReq, input logic mRdy);
        @(negedge clk);
        reset          = rst;
        ID_hazardStall = haz;
        EX_redirect    = redir;
        IF_ready       = ifRdy;
        MEM_req        = mReq;
        MEM_ready      = mRdy;
        #1;
    endtask

    task automatic checkCycle(input string tag, input logic [6:0] expCtrl,
                              input logic [1:0] expState);
        checkOutput({tag, " ctrl"}, 32'(ctrlObs), 32'(expCtrl));
        checkOutput({tag, " state"}, 32'(state_o), 32'(expState));
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        ID_hazardStall = 1'b0;
        EX_redirect    = 1'b0;
        IF_ready       = 1'b1;
        MEM_req        = 1'b0;
        MEM_ready      = 1'b0;

        // Reset with random inputs, then first idle cycle
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            checkOutput("reset ctrl", 32'(ctrlObs), 32'(EXP_RESET));
            checkOutput("reset timeout", 32'(mem_timeout), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("release", EXP_NORMAL, 2'd0);

        // Hazard stall, recovery, fetch wait
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("hazard", EXP_HAZARD, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("after hazard", EXP_NORMAL, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkCycle("fetchwait", EXP_FETCHWAIT, 2'd0);

        // Redirect overrides hazard and fetch wait
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkCycle("redirect", EXP_REDIRECT, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("discard", EXP_DISCARD, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("after discard", EXP_NORMAL, 2'd0);

        // Back-to-back redirects stay in REDIRECT
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkCycle("redirect A", EXP_REDIRECT, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkCycle("redirect B", EXP_REDIRECT, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("discard B", EXP_DISCARD, 2'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("after B", EXP_NORMAL, 2'd0);

        // Freeze masks a pending redirect, which is taken on release
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            checkCycle("freeze", EXP_FREEZE, (i == 0) ? 2'd0 : 2'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkCycle("unfreeze redirect", EXP_REDIRECT, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkCycle("unfreeze discard", EXP_DISCARD, 2'd2);

        // Wait count restarts from zero after a release
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkCycle("short release", EXP_NORMAL, 2'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput("recount timeout", 32'(mem_timeout), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("recount expired", 32'(mem_timeout), 32'd1);

        // Timeout rises after the 4th frozen cycle and is sticky until reset
        doReset();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("timeout cyc%0d", k), 32'(mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkCycle("timeout release", EXP_NORMAL, 2'd1);
        checkOutput("timeout held", 32'(mem_timeout), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("timeout sticky", 32'(mem_timeout), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("timeout in reset", 32'(mem_timeout), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("timeout cleared", 32'(mem_timeout), 32'd0);

`ifdef STALL_PERF_CNT_EN
        // Perf counters record only the winning event of each cycle
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("perf_hazard", perf_hazard, 32'd3);
        checkOutput("perf_redirect", perf_redirect, 32'd2);
        checkOutput("perf_memwait", perf_memwait, 32'd5);
        checkOutput("perf_fetchwait", perf_fetchwait, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
